// File: rtl/key_debounce_if.sv
// Button-side bundle for key_debounce: the raw active-low key in, the conditioned
// level and pulses out.
interface key_debounce_if;
    logic key_n;
    logic key_level;
    logic key_press;
    logic key_release;
    logic key_long;
    logic key_held;

    modport master (
        output key_n,
        input  key_level,
        input  key_press,
        input  key_release,
        input  key_long,
        input  key_held
    );

    modport slave (
        input  key_n,
        output key_level,
        output key_press,
        output key_release,
        output key_long,
        output key_held
    );
endinterface

// File: rtl/key_debounce.sv
// Debounces one raw active-low push-button into a clean level, press/release pulses
// and a long-press pulse plus flag, all registered in the clk_i domain.
//
// state        | meaning
// IDLE         | released and stable
// PRESS_WAIT   | low samples seen, counting towards an accepted press
// PRESSED      | pressed and stable
// RELEASE_WAIT | high samples seen, counting towards an accepted release
module key_debounce #(
    parameter int DEBOUNCE_TICKS = 3240000,
    parameter int LONG_TICKS     = 324000000
) (
    input  logic           clk_i,
    input  logic           reset_i,
    key_debounce_if.slave  kb_if
);
    localparam int DEB_W  = $clog2(DEBOUNCE_TICKS) + 1;
    localparam int HOLD_W = $clog2(LONG_TICKS) + 1;
    localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEBOUNCE_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_TICKS);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic               s1_q, s2_q;
    logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [HOLD_W-1:0]  hold_inc;
    logic               level_q, level_d;
    logic               press_q, press_d;
    logic               release_q, release_d;
    logic               long_q, long_d;
    logic               held_q, held_d;
    logic               release_acc;

    assign hold_inc = hold_cnt_q + HOLD_W'(1);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_q       <= 1'b1;
            s2_q       <= 1'b1;
            state_q    <= IDLE;
            deb_cnt_q  <= '0;
            hold_cnt_q <= '0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
            held_q     <= 1'b0;
        end else begin
            s1_q       <= kb_if.key_n;
            s2_q       <= s1_q;
            state_q    <= state_d;
            deb_cnt_q  <= deb_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
            held_q     <= held_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        deb_cnt_d   = deb_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        level_d     = level_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        held_d      = held_q;
        release_acc = 1'b0;

        case (state_q)
            IDLE: begin
                if (!s2_q) begin
                    state_d   = PRESS_WAIT;
                    deb_cnt_d = DEB_W'(1);
                end
            end
            PRESS_WAIT: begin
                if (s2_q) begin
                    state_d = IDLE;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d    = PRESSED;
                    level_d    = 1'b1;
                    press_d    = 1'b1;
                    hold_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            PRESSED: begin
                if (s2_q) begin
                    state_d   = RELEASE_WAIT;
                    deb_cnt_d = DEB_W'(1);
                end
            end
            RELEASE_WAIT: begin
                if (!s2_q) begin
                    state_d = PRESSED;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d     = IDLE;
                    level_d     = 1'b0;
                    release_d   = 1'b1;
                    held_d      = 1'b0;
                    hold_cnt_d  = '0;
                    release_acc = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // An accepted release on the maturity edge suppresses the long-press.
        if (level_q && !held_q && !release_acc) begin
            hold_cnt_d = hold_inc;
            if (hold_inc == HOLD_MAX) begin
                long_d = 1'b1;
                held_d = 1'b1;
            end
        end
    end

    assign kb_if.key_level   = level_q;
    assign kb_if.key_press   = press_q;
    assign kb_if.key_release = release_q;
    assign kb_if.key_long    = long_q;
    assign kb_if.key_held    = held_q;
endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce with DEBOUNCE_TICKS=4, LONG_TICKS=20; expected
// output vectors come from the edge-timing rules of each scenario.
module tb_key_debounce;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    key_debounce_if kb_if ();

    key_debounce #(
        .DEBOUNCE_TICKS (4),
        .LONG_TICKS     (20)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .kb_if   (kb_if)
    );

    logic [4:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic check_vec(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got {lvl,prs,rel,lng,hld}=%b expected %b", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expected result, compare after the edge.
    task automatic step(input string tag, input int i, input logic kn, input logic rst,
                        input logic [4:0] e);
        logic [4:0] got;
        kb_if.key_n = kn;
        reset       = rst;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = {kb_if.key_level, kb_if.key_press, kb_if.key_release,
               kb_if.key_long, kb_if.key_held};
        check_vec($sformatf("%s@%0d", tag, i), got, exp_q.pop_front());
    endtask

    // key_n low over [lo0,hi0) and [lo1,hi1); reset pulsed at rst_at.
    // pa/ra: press edge and clearing edge of a level window ended by reset (no release).
    // p/r/l: press, release and long-press edges (-1 = never).
    task automatic run_case(input string tag, input int n,
                            input int lo0, input int hi0, input int lo1, input int hi1,
                            input int rst_at, input int pa, input int ra,
                            input int p, input int r, input int l);
        for (int i = 0; i < n; i++) begin
            logic kn, lvl, prs, rel, lng, hld;
            kn  = !((i >= lo0 && i < hi0) || (i >= lo1 && i < hi1));
            lvl = (p >= 0 && i >= p && (r < 0 || i < r)) ||
                  (pa >= 0 && i >= pa && i < ra);
            prs = (i == p) || (i == pa);
            rel = (i == r);
            lng = (i == l);
            hld = (l >= 0 && i >= l && (r < 0 || i < r));
            step(tag, i, kn, (i == rst_at), {lvl, prs, rel, lng, hld});
        end
    endtask

    initial begin
        reset       = 1'b1;
        kb_if.key_n = 1'b1;
        step("reset", 0, 1'b1, 1'b1, 5'b0);
        step("reset", 1, 1'b1, 1'b1, 5'b0);
        step("idle",  2, 1'b1, 1'b0, 5'b0);

        //       tag          n   lo0 hi0 lo1 hi1 rst pa  ra  p   r   l
        run_case("clean",     25, 2,  14, -1, -1, -1, -1, -1, 7,  19, -1);
        run_case("bounce",    16, 2,  5,  6,  8,  -1, -1, -1, -1, -1, -1);
        run_case("long",      52, 2,  42, -1, -1, -1, -1, -1, 7,  47, 27);
        run_case("rel_bnc",   50, 2,  9,  11, 40, -1, -1, -1, 7,  45, 27);
        run_case("collide",   32, 2,  22, -1, -1, -1, -1, -1, 7,  27, -1);
        run_case("rst_mid",   30, 2,  20, -1, -1, 10, 7,  10, 16, 25, -1);
        run_case("clean2",    25, 3,  15, -1, -1, -1, -1, -1, 8,  20, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/key_debounce.md
# key_debounce

Conditions one raw, active-low, asynchronous push-button (KEY1/KEY2 on the Tang Nano 4K) into clean, single-clock-domain control signals. It provides a debounced level, one-cycle press/release pulses, and a long-press pulse and flag. It sits directly upstream of the top-level logic that consumes the keys: the LED source select, the M3 GPIO input vector and the M3 reset request. Each key gets one instance, clocked by the PLL fabric clock.

## Interface
- DEBOUNCE_TICKS, 3240000: consecutive identical synchronized samples required to accept a level change (10 ms at 324 MHz); legal range ≥2.
- LONG_TICKS, 324000000: cycles of accepted press before long-press fires (1 s at 324 MHz); must exceed DEBOUNCE_TICKS.
- Counter widths: $clog2 of the respective parameter plus 1.
- clk  in  1  fabric clock; one clock domain, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- key_n  in  1  raw button, low = pressed, asynchronous to clk.
- key_level  out  1  debounced state, 1 = pressed.
- key_press  out  1  one-cycle pulse on accepted press.
- key_release  out  1  one-cycle pulse on accepted release.
- key_long  out  1  one-cycle pulse when press duration reaches LONG_TICKS.
- key_held  out  1  level; 1 from key_long until accepted release.

## Operation
- Two-flop synchronizer s1→s2 on key_n; both reset to 1 (released). s2 is "the sample".
- All outputs are registered and 0 in reset. State is IDLE and both counters are 0 in reset.
- States:
  - IDLE: released and stable. Sample 0 → PRESS_WAIT with deb_cnt=1.
  - PRESS_WAIT: sample 1 → IDLE (bounce rejected, no output). Sample 0 with deb_cnt==DEBOUNCE_TICKS-1 → PRESSED, key_level=1, key_press=1, hold_cnt=0. Otherwise deb_cnt++.
  - PRESSED: sample 1 → RELEASE_WAIT with deb_cnt=1.
  - RELEASE_WAIT: sample 0 → PRESSED (bounce rejected). Sample 1 with deb_cnt==DEBOUNCE_TICKS-1 → IDLE, key_level=0, key_release=1, key_held=0, hold_cnt=0. Otherwise deb_cnt++.
- hold_cnt:
  - Increments every cycle while key_level=1 and key_held=0, in both PRESSED and RELEASE_WAIT. A bounce does not restart it.
  - The increment that brings hold_cnt to LONG_TICKS sets key_long=1 for one cycle and key_held=1. hold_cnt then freezes until release.
- Accepted release on the same edge that long-press would mature: release wins; key_long stays 0 and key_held stays 0.
- key_press, key_release and key_long are mutually exclusive in any cycle. At most one key_long per press.
- Reset mid-operation: returns to IDLE with all outputs 0 on the next edge; no release pulse. If the key is still held after reset deasserts, the press is re-detected normally, with a full debounce and a fresh key_press.

## Timing
- E0 = first clk edge at which key_n is low.
- key_level rises and key_press pulses at edge E0+DEBOUNCE_TICKS+1, provided key_n stays low throughout. Release is symmetric.
- key_long pulses exactly LONG_TICKS edges after the key_press edge.
- Any opposite sample during a wait state aborts it. The debounce window restarts from zero on the next qualifying sample.
- Minimum accepted pulse width is DEBOUNCE_TICKS clock cycles. Shorter glitches produce no output change.
- No combinational path from key_n to any output.

## Test plan
Bench parameters are DEBOUNCE_TICKS=4 and LONG_TICKS=20.
- Clean press: key_n held 1 then low from E0 → key_press=1 and key_level=1 at E0+5. No pulse before that; key_long=0.
- Bounce: key_n low 3 cycles, high 1, low 2, high → no output activity. key_level stays 0 and state returns to IDLE.
- Long press: low for 40 cycles → key_press at E0+5, key_long single pulse at E0+25, key_held=1 until the release is accepted 5 edges after key_n rises, coinciding with key_release=1.
- Release bounce while pressed: after the press is accepted, key_n high 2 cycles then low → key_level stays 1, no key_release. hold_cnt is not reset, so key_long still fires at press+20.
- Release colliding with long maturity: release accepted on the same edge hold_cnt would reach 20 → key_release=1, key_long=0, key_held=0.
- Reset mid-press: assert reset for 1 cycle while key_level=1 and key held low → all outputs 0 next edge. After reset deasserts, a new key_press arrives 5 edges after the first post-reset sampling edge.
